// File: rtl/axi_gpio_pwm_if.sv
// AXI4-Lite control-bus bundle for the GPIO/PWM peripheral; pure wiring, no latency.
// Slave drives the ready/valid-response side, master drives address/data/valid.
interface axi_gpio_pwm_if;
   logic [3:0]  AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi_gpio_pwm.sv
// AXI4-Lite GPIO + PWM peripheral: B and R valid one cycle after the AW/W or AR ready pulse.
// No new write while BVALID is pending and no new read while RVALID is pending; responses hold until accepted.
module axi_gpio_pwm (
   input  logic                  ACLK,
   input  logic                  ARESET_N,
   axi_gpio_pwm_if.slave         s_axi,
   input  logic [7:0]            gpio_in,
   output logic [7:0]            gpio_out,
   output logic                  pwm_out
);

   logic        aw_rdy_q, aw_rdy_d;
   logic        b_vld_q, b_vld_d;
   logic        ar_rdy_q, ar_rdy_d;
   logic        r_vld_q, r_vld_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  gpo_q, gpo_d;
   logic [31:0] duty_q, duty_d;
   logic [31:0] period_q, period_d;
   logic [31:0] cnt_q, cnt_d;
   logic        pwm_q, pwm_d;
   logic [7:0]  sync1_q, sync2_q;
   logic [31:0] rd_mux;
   logic        wr_fire;
   logic        rd_fire;
   logic        unused_addr_bits;

   assign wr_fire = aw_rdy_q && s_axi.AWVALID && s_axi.WVALID;
   assign rd_fire = ar_rdy_q && s_axi.ARVALID;
   assign unused_addr_bits = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      aw_rdy_d = 1'b0;
      b_vld_d  = b_vld_q;
      ar_rdy_d = 1'b0;
      r_vld_d  = r_vld_q;
      rdata_d  = rdata_q;
      gpo_d    = gpo_q;
      duty_d   = duty_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      pwm_d    = 1'b0;
      rd_mux   = 32'h0;

      // Write path: one-cycle ready pulse, response held until BREADY
      aw_rdy_d = s_axi.AWVALID && s_axi.WVALID && !b_vld_q && !aw_rdy_q;
      if (wr_fire) begin
         b_vld_d = 1'b1;
         case (s_axi.AWADDR[3:2])
            2'd0: if (s_axi.WSTRB[0]) gpo_d = s_axi.WDATA[7:0];
            2'd2: duty_d   = merge_lanes(duty_q, s_axi.WDATA, s_axi.WSTRB);
            2'd3: period_d = merge_lanes(period_q, s_axi.WDATA, s_axi.WSTRB);
            default: ;
         endcase
      end else if (b_vld_q && s_axi.BREADY) begin
         b_vld_d = 1'b0;
      end

      // Read path samples current register values, so a same-cycle write is not seen
      case (s_axi.ARADDR[3:2])
         2'd0:    rd_mux = {24'h0, gpo_q};
         2'd1:    rd_mux = {24'h0, sync2_q};
         2'd2:    rd_mux = duty_q;
         default: rd_mux = period_q;
      endcase
      ar_rdy_d = s_axi.ARVALID && !r_vld_q && !ar_rdy_q;
      if (rd_fire) begin
         r_vld_d = 1'b1;
         rdata_d = rd_mux;
      end else if (r_vld_q && s_axi.RREADY) begin
         r_vld_d = 1'b0;
      end

      // A count at or past the period boundary (including after a shrink) wraps to 0
      if (period_q == 32'h0) begin
         cnt_d = 32'h0;
         pwm_d = 1'b0;
      end else begin
         cnt_d = (cnt_q >= period_q - 32'd1) ? 32'h0 : cnt_q + 32'd1;
         pwm_d = (cnt_q < duty_q);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET_N) begin
         aw_rdy_q <= 1'b0;
         b_vld_q  <= 1'b0;
         ar_rdy_q <= 1'b0;
         r_vld_q  <= 1'b0;
         rdata_q  <= 32'h0;
         gpo_q    <= 8'h0;
         duty_q   <= 32'h0;
         period_q <= 32'h0;
         cnt_q    <= 32'h0;
         pwm_q    <= 1'b0;
         sync1_q  <= 8'h0;
         sync2_q  <= 8'h0;
      end else begin
         aw_rdy_q <= aw_rdy_d;
         b_vld_q  <= b_vld_d;
         ar_rdy_q <= ar_rdy_d;
         r_vld_q  <= r_vld_d;
         rdata_q  <= rdata_d;
         gpo_q    <= gpo_d;
         duty_q   <= duty_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         pwm_q    <= pwm_d;
         sync1_q  <= gpio_in;
         sync2_q  <= sync1_q;
      end
   end

   assign s_axi.AWREADY = aw_rdy_q;
   assign s_axi.WREADY  = aw_rdy_q;
   assign s_axi.BVALID  = b_vld_q;
   assign s_axi.BRESP   = 2'b00;
   assign s_axi.ARREADY = ar_rdy_q;
   assign s_axi.RVALID  = r_vld_q;
   assign s_axi.RDATA   = rdata_q;
   assign s_axi.RRESP   = 2'b00;
   assign gpio_out      = gpo_q;
   assign pwm_out       = pwm_q;

endmodule

// File: tb/tb_axi_gpio_pwm.sv
// Bench for axi_gpio_pwm: vector table, hand sequences for backpressure/reset, random traffic vs. a register-map model.
// PWM is judged by duty counts, periodicity and run lengths over whole-period windows.
module tb_axi_gpio_pwm;

   logic       ACLK = 1'b0;
   logic       ARESET_N;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       pwm_out;

   axi_gpio_pwm_if bus ();

   axi_gpio_pwm dut (
      .ACLK     (ACLK),
      .ARESET_N (ARESET_N),
      .s_axi    (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .pwm_out  (pwm_out)
   );

   always #5 ACLK = ~ACLK;

   int          cmp_n = 0;
   int          err_n = 0;
   logic [31:0] model_reg [4];
   logic [7:0]  gpio_model;

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      cmp_n++;
      err_n++;
      $display("FAIL %s: wait bound of 20 cycles expired", name);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic bus_idle();
      bus.AWADDR = 4'h0; bus.AWVALID = 1'b0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0;
      bus.WVALID = 1'b0; bus.BREADY = 1'b1; bus.ARADDR = 4'h0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) model_reg[i] = 32'h0;
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a[3:2] != 2'd1) begin
         for (int i = 0; i < 4; i++) begin
            if (s[i]) model_reg[a[3:2]][8*i +: 8] = d[8*i +: 8];
         end
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return {24'h0, model_reg[0][7:0]};
         2'd1:    return {24'h0, gpio_model};
         default: return model_reg[a[3:2]];
      endcase
   endfunction

   task automatic wait_awready(output bit ok);
      int n = 0;
      while (bus.AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
      ok = (bus.AWREADY === 1'b1);
      if (!ok) fail_now("awready_timeout");
   endtask

   task automatic wait_arready(output bit ok);
      int n = 0;
      while (bus.ARREADY !== 1'b1 && n < 20) begin tick(); n++; end
      ok = (bus.ARREADY === 1'b1);
      if (!ok) fail_now("arready_timeout");
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit ok;
      bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
      wait_awready(ok);
      if (!ok) begin bus.AWVALID = 1'b0; bus.WVALID = 1'b0; return; end
      check("wready_with_awready", bus.WREADY, 1);
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      model_write(a, d, s);
      check("bvalid_after_hs", bus.BVALID, 1);
      check("bresp_okay", bus.BRESP, 0);
      check("awready_one_cycle", bus.AWREADY, 0);
      tick();
      check("bvalid_cleared", bus.BVALID, 0);
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      bit ok;
      d = 32'hx;
      bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
      wait_arready(ok);
      if (!ok) begin bus.ARVALID = 1'b0; return; end
      tick();
      bus.ARVALID = 1'b0;
      check("rvalid_after_hs", bus.RVALID, 1);
      check("rresp_okay", bus.RRESP, 0);
      d = bus.RDATA;
      tick();
      check("rvalid_cleared", bus.RVALID, 0);
   endtask

   task automatic check_pwm(input string name, input int duty, input int period, input bit runs);
      bit s[$];
      int win, hi, mism, expect_hi;
      axi_write(4'h8, duty, 4'hF);
      axi_write(4'hC, period, 4'hF);
      tick(2 * period + 5);
      win = (period == 0) ? 64 : 3 * period;
      for (int i = 0; i < win; i++) begin
         s.push_back(pwm_out);
         tick();
      end
      hi = 0;
      foreach (s[i]) if (s[i]) hi++;
      expect_hi = (period == 0) ? 0 : 3 * ((duty < period) ? duty : period);
      check({name, "_high_count"}, hi, expect_hi);
      if (period > 0) begin
         mism = 0;
         for (int i = 0; i < 2 * period; i++) if (s[i] != s[i + period]) mism++;
         check({name, "_periodic"}, mism, 0);
      end
      if (runs) begin
         int rise = -1, h = 0, l = 0, k;
         for (int i = 1; i < 2 * period; i++) if (rise < 0 && s[i] && !s[i-1]) rise = i;
         if (rise < 0) begin
            fail_now({name, "_no_rising_edge"});
         end else begin
            k = rise;
            while (k < win && s[k]) begin h++; k++; end
            while (k < win && !s[k]) begin l++; k++; end
            check({name, "_high_run"}, h, duty);
            check({name, "_low_run"}, l, period - duty);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt [14];
      logic [31:0] rd, r0;
      bit          ok;
      int          bad_b, bad_aw, bad_r;

      vt[0]  = '{1'b1, 4'h0, 32'h000000AA, 4'hF, 32'hAA};
      vt[1]  = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h000000AA};
      vt[2]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h0000003C};
      vt[3]  = '{1'b1, 4'h4, 32'h000000FF, 4'hF, 32'hAA};
      vt[4]  = '{1'b0, 4'h4, 32'h0,        4'h0, 32'h0000003C};
      vt[5]  = '{1'b1, 4'h8, 32'h00000000, 4'hF, 32'hAA};
      vt[6]  = '{1'b1, 4'h8, 32'h11223344, 4'h1, 32'hAA};
      vt[7]  = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h00000044};
      vt[8]  = '{1'b1, 4'hC, 32'h12345678, 4'h6, 32'hAA};
      vt[9]  = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h00345600};
      vt[10] = '{1'b1, 4'h3, 32'hFFFFFF55, 4'h1, 32'h55};
      vt[11] = '{1'b0, 4'h1, 32'h0,        4'h0, 32'h00000055};
      vt[12] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'hE, 32'h55};
      vt[13] = '{1'b0, 4'h2, 32'h0,        4'h0, 32'h00000055};

      // Reset held for five cycles
      bus_idle();
      gpio_in = 8'h00;
      gpio_model = 8'h00;
      model_clear();
      ARESET_N = 1'b1;
      tick(5);
      ARESET_N = 1'b0;
      tick();
      check("rst_gpio_out", gpio_out, 0);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_ready_valid", {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID}, 0);
      check("rst_rdata", bus.RDATA, 0);
      check("rst_resp", {bus.BRESP, bus.RRESP}, 0);
      axi_read(4'h0, rd); check("rst_read_0", rd, 0);
      axi_read(4'h8, rd); check("rst_read_8", rd, 0);
      axi_read(4'hC, rd); check("rst_read_c", rd, 0);

      gpio_in = 8'h3C;
      gpio_model = 8'h3C;
      tick(3);
      for (int i = 0; i < 14; i++) begin
         if (vt[i].wr) begin
            axi_write(vt[i].addr, vt[i].data, vt[i].strb);
            check($sformatf("vec%0d_gpio_out", i), gpio_out, vt[i].exp);
         end else begin
            axi_read(vt[i].addr, rd);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
         end
      end

      // Read and write of the same register completing together
      bus.AWADDR = 4'h8; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARADDR = 4'h8; bus.ARVALID = 1'b1;
      tick();
      check("same_cycle_readies", {bus.AWREADY, bus.ARREADY}, 2'b11);
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      check("same_cycle_valids", {bus.BVALID, bus.RVALID}, 2'b11);
      check("same_cycle_old_data", bus.RDATA, 32'h00000044);
      model_write(4'h8, 32'hDEADBEEF, 4'hF);
      tick();
      axi_read(4'h8, rd); check("same_cycle_new_data", rd, 32'hDEADBEEF);

      // Write response backpressure with a second write waiting
      bus.BREADY = 1'b0;
      bus.AWADDR = 4'h0; bus.WDATA = 32'h5A; bus.WSTRB = 4'hF;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
      wait_awready(ok);
      tick();
      model_write(4'h0, 32'h5A, 4'hF);
      bus.WDATA = 32'hC3;
      bad_b = 0; bad_aw = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.BVALID !== 1'b1) bad_b++;
         if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) bad_aw++;
         tick();
      end
      check("bp_bvalid_held", bad_b, 0);
      check("bp_no_second_accept", bad_aw, 0);
      check("bp_gpio_first", gpio_out, 8'h5A);
      bus.BREADY = 1'b1;
      tick();
      check("bp_bvalid_released", bus.BVALID, 0);
      wait_awready(ok);
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      model_write(4'h0, 32'hC3, 4'hF);
      check("bp_second_bvalid", bus.BVALID, 1);
      check("bp_gpio_second", gpio_out, 8'hC3);
      tick();

      // Read data backpressure while a write to the same register completes
      bus.RREADY = 1'b0;
      bus.ARADDR = 4'h0; bus.ARVALID = 1'b1;
      wait_arready(ok);
      tick();
      bus.ARVALID = 1'b0;
      r0 = bus.RDATA;
      check("rbp_first_data", r0, 32'h000000C3);
      axi_write(4'h0, 32'h77, 4'hF);
      bad_r = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.RVALID !== 1'b1 || bus.RDATA !== r0) bad_r++;
         tick();
      end
      check("rbp_rdata_stable", bad_r, 0);
      check("rbp_gpio_new", gpio_out, 8'h77);
      bus.RREADY = 1'b1;
      tick();
      check("rbp_rvalid_released", bus.RVALID, 0);

      // PWM
      check_pwm("pwm_100_200", 100, 200, 1'b1);
      check_pwm("pwm_duty0", 0, 200, 1'b0);
      check_pwm("pwm_duty250", 250, 200, 1'b0);
      check_pwm("pwm_period0", 250, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check_pwm($sformatf("pwm_rand%0d", i), $urandom_range(0, 50), $urandom_range(1, 40), 1'b0);
      end

      // Random register traffic against the register-map model
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  a;
         logic [31:0] d;
         if ($urandom_range(0, 3) == 0) begin
            gpio_in = 8'($urandom);
            gpio_model = gpio_in;
            tick(3);
         end
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            axi_write(a, d, 4'($urandom_range(0, 15)));
            check($sformatf("rand%0d_gpio_out", i), gpio_out, {24'h0, model_reg[0][7:0]});
         end else begin
            axi_read(a, rd);
            check($sformatf("rand%0d_rdata", i), rd, exp_read(a));
         end
      end

      // Reset in the middle of pending responses
      axi_write(4'h8, 32'd5, 4'hF);
      axi_write(4'hC, 32'd10, 4'hF);
      axi_write(4'h0, 32'hE1, 4'hF);
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      bus.AWADDR = 4'h0; bus.WDATA = 32'h12; bus.WSTRB = 4'hF;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARADDR = 4'hC; bus.ARVALID = 1'b1;
      tick(3);
      check("mid_pending", {bus.BVALID, bus.RVALID}, 2'b11);
      ARESET_N = 1'b1;
      tick();
      bus_idle();
      check("mid_rst_handshake", {bus.AWREADY, bus.BVALID, bus.ARREADY, bus.RVALID}, 0);
      check("mid_rst_rdata", bus.RDATA, 0);
      check("mid_rst_gpio_out", gpio_out, 0);
      ARESET_N = 1'b0;
      model_clear();
      gpio_model = gpio_in;
      bad_r = 0;
      for (int i = 0; i < 20; i++) begin
         if (pwm_out !== 1'b0) bad_r++;
         tick();
      end
      check("mid_rst_pwm_idle", bad_r, 0);
      axi_read(4'h8, rd); check("mid_rst_duty", rd, 0);
      axi_read(4'hC, rd); check("mid_rst_period", rd, 0);
      axi_read(4'h0, rd); check("mid_rst_gpio_reg", rd, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule

// File: doc/axi_gpio_pwm.md
Name: axi_gpio_pwm

Overview:
AXI4-Lite slave peripheral with an 8-bit GPIO output register, an 8-bit GPIO input port and a single-channel PWM generator. It sits on the SoC control bus, and software programs it through four 32-bit registers. Single clock domain (ACLK).

Parameters:
- none; all widths fixed (address 4 bits, data 32 bits, GPIO 8 bits, PWM counter 32 bits).

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESET_N  in  1  reset; synchronous, active-high. The port keeps the codebase name; asserting it (1) resets the block on the next ACLK edge.
- AWADDR  in  4  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  write byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response, always 2'b00 (OKAY).
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  4  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response, always 2'b00 (OKAY).
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- gpio_in  in  8  external inputs, asynchronous.
- gpio_out  out  8  external outputs, driven by GPIO_OUT[7:0].
- pwm_out  out  1  PWM waveform.

Behaviour:
- Register map (decode AWADDR/ARADDR[3:2]; bits [1:0] ignored):
  - 0x0 GPIO_OUT: RW. Bits [7:0] are stored; upper bits read 0.
  - 0x4 GPIO_IN: RO. Reads the synchronized gpio_in, zero-extended. Writes are ignored.
  - 0x8 PWM_DUTY: RW, 32 bits.
  - 0xC PWM_PERIOD: RW, 32 bits.
- Reset: all registers 0, gpio_out=0, pwm_out=0, PWM counter=0. All ready/valid outputs 0, RDATA=0, BRESP/RRESP=0.
- Write channel:
  - When AWVALID && WVALID && !BVALID && !(AWREADY), assert AWREADY and WREADY together for exactly one cycle.
  - The register updates on that handshake edge, per byte lane where WSTRB[i]=1.
  - BVALID rises on the cycle after the handshake and holds until BVALID && BREADY, then clears.
  - No new write is accepted while BVALID=1.
  - AW without W, or W without AW: wait; no partial acceptance.
- Read channel:
  - When ARVALID && !RVALID && !ARREADY, assert ARREADY for one cycle.
  - On the handshake edge, capture RDATA from the addressed register and set RVALID.
  - RDATA/RVALID hold stable until RVALID && RREADY, then RVALID clears.
  - Read latency: RVALID one cycle after the ARREADY pulse.
- Read and write channels are independent and may complete in the same cycle. A read of a register written in the same cycle returns the old value.
- gpio_in passes through a 2-flop synchronizer; GPIO_IN reflects a pin change within 2 cycles.
- gpio_out updates on the write-handshake edge and is visible the next cycle.
- PWM:
  - Free-running 32-bit counter. If PERIOD==0: counter held at 0 and pwm_out=0.
  - Else counter increments each cycle and wraps to 0 when counter >= PERIOD-1. A PERIOD shrink below the current count wraps on the next cycle.
  - pwm_out is registered: pwm_out <= (counter < DUTY).
  - DUTY=0 gives constant 0. DUTY>=PERIOD (PERIOD≠0) gives constant 1.
  - New DUTY/PERIOD values take effect immediately; no shadowing.
- Reset asserted mid-transaction aborts it: valid/ready drop to 0 and registers return to 0.

Test Plan:
- Reset: hold ARESET_N=1 for 5 cycles, then release → all outputs 0. Read 0x0, 0x8, 0xC → 0x00000000.
- GPIO out: write 0x0=0x000000AA with WSTRB=4'hF → BVALID one cycle after handshake, BRESP=0. gpio_out=0xAA; read 0x0 returns 0x000000AA.
- GPIO in: gpio_in=0x3C, wait 3 cycles, read 0x4 → 0x0000003C. Write 0x4=0xFF → read still 0x3C.
- Byte strobes: write 0x8=0x11223344 with WSTRB=4'b0001 after 0x8=0 → read 0x8 = 0x00000044.
- PWM: write DUTY=100, PERIOD=200 → pwm_out high 100 cycles, low 100 cycles, repeating every 200 cycles. DUTY=0 → constant 0. DUTY=250 → constant 1. PERIOD=0 → constant 0.
- Backpressure: keep BREADY=0 for 10 cycles after a write → BVALID held and a second AW/W not accepted. Keep RREADY=0 after a read → RDATA stable until RREADY.
